// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM, the datapath mux
// selects and the ALU decoder.
`timescale 1ns/1ps
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic is_supported(input logic [6:0] op);
    return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RISC-V core (Moore, state-decoded outputs).
// Define MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on mem_ready.
`timescale 1ns/1ps
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t state;
  logic   ready;

`ifdef MEM_WAIT_EN
  assign ready = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign ready = 1'b1;
`endif

  // NOTE: asynchronous reset belongs in the sensitivity list; state uses <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXECUTER;
            OP_I:         state <= S_EXECUTEI;
            OP_BEQ:       state <= S_BEQ;
            OP_JAL:       state <= S_JAL;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (op == OP_LW)      state <= S_MEMREAD;
          else if (op == OP_SW) state <= S_MEMWRITE;
          else                  state <= S_FETCH;
        end
        S_MEMREAD:  if (ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (ready) state <= S_FETCH;
        S_EXECUTER: state <= S_ALUWB;
        S_EXECUTEI: state <= S_ALUWB;
        S_JAL:      state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    IRWrite    = 1'b0;
    PCUpdate   = 1'b0;
    Branch     = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_B;
    ResultSrc  = RES_ALUOUT;
    ALUOp      = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite   = ready;
        PCUpdate  = ready;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        illegal_op = !is_supported(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = ready;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_A;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        PCUpdate = 1'b1;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_A;
        ALUOp   = ALUOP_SUB;
        Branch  = 1'b1;
      end
      default: ;
    endcase
    // Reset kills every enable at once, even mid-instruction.
    if (rst) begin
      IRWrite    = 1'b0;
      PCUpdate   = 1'b0;
      Branch     = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed and random opcode streams
// against a per-instruction path model; follows MEM_WAIT_EN if defined.
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;
  import ctrl_pkg::*;

`ifdef MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  typedef struct packed {
    logic [3:0] st;
    logic       irw, pcu, br, rw, mw, adr;
    logic [1:0] a, b, res, aop;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       mem_ready;
  logic       IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc, illegal_op;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int low_fetch = 0;
  int low_mw    = 0;
  int waits     = 0;
  bit random_mode = 1'b0;
  logic [6:0] cur_op;
  logic [6:0] ops [6] = '{LW, SW, RT, IT, BEQ, JAL};
  state_t path [$];

  multicycle_ctrl_fsm dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Expected outputs of one cycle spent in a given phase.
  function automatic exp_t exp_of(input state_t ph, input bit rdy, input bit ill, input bit in_rst);
    exp_t e = '0;
    bit   g = !WAIT_EN || rdy;
    e.st = ph;
    case (ph)
      S_FETCH:    begin e.irw = g; e.pcu = g; e.b = 2'b10; e.res = 2'b10; end
      S_DECODE:   begin e.a = 2'b01; e.b = 2'b01; e.ill = ill; end
      S_MEMADR:   begin e.a = 2'b10; e.b = 2'b01; end
      S_MEMREAD:  e.adr = 1'b1;
      S_MEMWB:    begin e.res = 2'b01; e.rw = 1'b1; end
      S_MEMWRITE: begin e.adr = 1'b1; e.mw = g; end
      S_EXECUTER: begin e.a = 2'b10; e.aop = 2'b10; end
      S_EXECUTEI: begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
      S_JAL:      begin e.a = 2'b01; e.b = 2'b10; e.pcu = 1'b1; end
      S_ALUWB:    e.rw = 1'b1;
      S_BEQ:      begin e.a = 2'b10; e.aop = 2'b01; e.br = 1'b1; end
      default: ;
    endcase
    if (in_rst) {e.irw, e.pcu, e.br, e.rw, e.mw, e.ill} = '0;
    return e;
  endfunction

  function automatic void build_path(input logic [6:0] opc);
    case (opc)
      LW:      path = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
      SW:      path = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE};
      RT:      path = '{S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB};
      IT:      path = '{S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB};
      BEQ:     path = '{S_FETCH, S_DECODE, S_BEQ};
      JAL:     path = '{S_FETCH, S_DECODE, S_JAL, S_ALUWB};
      default: path = '{S_FETCH, S_DECODE};
    endcase
  endfunction

  function automatic bit pick_ready(input state_t ph);
    if (ph == S_FETCH && low_fetch > 0) begin low_fetch--; return 1'b0; end
    if (ph == S_MEMWRITE && low_mw > 0) begin low_mw--; return 1'b0; end
    if (random_mode && waits < 6 && $urandom_range(0, 3) == 0) begin
      waits++;
      return 1'b0;
    end
    waits = 0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input exp_t e);
    exp_t obs;
    obs = {state_o, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUOp, illegal_op};
    n_checks++;
    assert (obs === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, e);
    end
  endtask

  // One phase of an instruction; wait-capable phases repeat while stalled.
  task automatic step(input state_t ph, input bit ill, input int idx);
    bit again;
    do begin
      @(negedge clk);
      if (ph == S_DECODE) op = cur_op;
      mem_ready = pick_ready(ph);
      #1 check($sformatf("i%0d_%s", idx, ph.name()), exp_of(ph, mem_ready, ill, 1'b0));
      again = WAIT_EN && (ph inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !mem_ready;
    end while (again);
  endtask

  task automatic run_instr(input logic [6:0] opc, input int idx, input int max_phases);
    bit ill;
    cur_op = opc;
    ill = !(opc inside {LW, SW, RT, IT, BEQ, JAL});
    build_path(opc);
    for (int i = 0; i < path.size() && i < max_phases; i++) step(path[i], ill, idx);
  endtask

  initial begin
    logic [6:0] opc;
    rst = 1'b1;
    op = 7'd0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset", exp_of(S_FETCH, 1'b1, 1'b0, 1'b1));
    rst = 1'b0;
    #1 check("first_fetch", exp_of(S_FETCH, 1'b1, 1'b0, 1'b0));

    // Directed: every opcode class plus an unsupported one.
    run_instr(LW, 0, 99);
    run_instr(SW, 1, 99);
    run_instr(RT, 2, 99);
    run_instr(IT, 3, 99);
    run_instr(BEQ, 4, 99);
    run_instr(JAL, 5, 99);
    run_instr(7'b0000000, 6, 99);
    run_instr(IT, 7, 99);

    // Abort an R-type in EXECUTER with an asynchronous reset.
    run_instr(RT, 8, 3);
    #2 rst = 1'b1;
    #1 check("rst_async", exp_of(S_FETCH, 1'b1, 1'b0, 1'b1));
    @(posedge clk);
    #1 check("rst_held", exp_of(S_FETCH, 1'b1, 1'b0, 1'b1));
    mem_ready = 1'b1;
    rst = 1'b0;
    #1 check("rst_release", exp_of(S_FETCH, 1'b1, 1'b0, 1'b0));

    // Stall patterns (no effect without MEM_WAIT_EN).
    low_fetch = 3;
    run_instr(LW, 9, 99);
    low_mw = 2;
    run_instr(SW, 10, 99);

    random_mode = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do opc = 7'($urandom); while (opc inside {LW, SW, RT, IT, BEQ, JAL});
      end else begin
        opc = ops[$urandom_range(0, 5)];
      end
      run_instr(opc, 100 + n, 99);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Main control state machine of the multicycle RISC-V core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and the write enables, including IRWrite to the instruction register and OldPC capture.
- Sits directly upstream of the instruction register: the IR loads `RD` and `PC` only in cycles where this block asserts IRWrite.
- Supported opcodes: lw, sw, R-type, I-type ALU, beq, jal.

## Interface
Parameters:
- (none; state encoding and opcode constants come from `ctrl_pkg`)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- op  in  7  opcode field of the IR output (`Instr[6:0]`)
- mem_ready  in  1  memory access completes this cycle; used only with `MEM_WAIT_EN`
- IRWrite  out  1  IR and OldPC load enable
- PCUpdate  out  1  unconditional PC write
- Branch  out  1  PC write qualified by datapath Zero
- RegWrite  out  1  register file write
- MemWrite  out  1  data memory write
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A reg
- ALUSrcB  out  2  00 = B reg, 01 = ImmExt, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data reg, 10 = ALUResult
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state_o  out  4  current state, for debug

## Operation
- Moore FSM; outputs decode from the state register only, except the `MEM_WAIT_EN` qualification below.
- Every select not listed for a state is 00 / 0. Every enable not listed is 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by `op`:
  - lw 0000011 / sw 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → FETCH, with illegal_op=1 in this cycle
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state by the `op` held in the IR: lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 → FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 → FETCH.
- Unreachable state encodings → FETCH, with all enables 0 in that cycle.

## Timing
- Reset: state=FETCH asynchronously. While rst=1, IRWrite, PCUpdate, Branch, RegWrite, MemWrite and illegal_op are forced to 0. Selects show their FETCH values; state_o=0.
- First IRWrite occurs in the first clk edge cycle after rst deasserts.
- Reset asserted mid-instruction: the instruction is aborted with no further enables; fetch restarts at the reset PC.
- Cycles per instruction: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- IRWrite and PCUpdate are high in the same cycle. The IR captures `RD` and the pre-increment PC on that edge.
- `op` is sampled in DECODE and MEMADR only, when the IR is stable.

## Configuration
- `MEM_WAIT_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold their state while mem_ready=0.
  - In FETCH, IRWrite and PCUpdate are gated by mem_ready.
  - In MEMWRITE, MemWrite is gated by mem_ready.
  - Each wait cycle adds one cycle to CPI. mem_ready=1 continuously gives the undefined-macro timing.
- `MEM_WAIT_EN` undefined: mem_ready is ignored, and every memory state lasts exactly one cycle.

## Structure
- `ctrl_pkg` holds:
  - the state enum (4-bit, FETCH=0)
  - the opcode localparams
  - the ALUSrcA, ALUSrcB, ResultSrc and ALUOp encodings, shared with the datapath and the ALU decoder
- No sub-module. The ALU decoder is a separate sibling block fed by ALUOp.

## Test plan
- Reset mid-EXECUTER, release → state_o=0 at once; IRWrite=0 while rst=1, then IRWrite=1 in the first cycle after release.
- Opcode sequence lw, sw, R, I, beq, jal → state paths exactly as listed above; durations 5, 4, 4, 4, 3, 4 cycles; RegWrite/MemWrite pulse once in the specified states.
- Opcode 0000000 → DECODE gives illegal_op=1 for one cycle; FETCH on the next cycle; no RegWrite or MemWrite.
- jal → PCUpdate high in FETCH and in JAL, RegWrite in ALUWB; beq → Branch=1 for exactly one cycle, ALUOp=01.
- `MEM_WAIT_EN`, mem_ready low for 3 cycles in FETCH → IRWrite=0 and PCUpdate=0 for those cycles, then both 1 for one cycle; total lw CPI = 8.
- `MEM_WAIT_EN`, sw with mem_ready low for 2 cycles in MEMWRITE → MemWrite high only in the ready cycle; then FETCH.
